md_unit_param: RTL and testbench

- Parametrised multiply/divide unit for the E stage of the pipelined MIPS core, owning the architectural HI/LO registers.
- Generalises the fixed 32-bit MD unit:
  - width, multiply latency and divide latency are parameters;
  - operations arrive as an opcode instead of a raw instruction;
  - divide-by-zero and signed-overflow results are defined;
  - the D-stage stall is precise (fires only for HI/LO users);
  - multiply-accumulate ops are optional.

---
 rtl/md_unit_param.sv | 180 ++++++++++++++++++
 tb/tb_md_unit_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_param.sv
// md_unit_param: parametrised multiply/divide unit owning the HI/LO registers.
// Multi-cycle results are computed at accept into shadow registers and become
// architectural when the down-counter expires. Build option MD_ACC_EN enables
// the MADD/MADDU/MSUB/MSUBU accumulate ops; otherwise ops 9-12 are NOPs.
module md_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             d_md_use,
  output logic [WIDTH-1:0] hl_rdata,
  output logic             busy,
  output logic             stall
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0]    MUL_CNT  = CW'(MUL_LAT);
  localparam logic [CW-1:0]    DIV_CNT  = CW'(DIV_LAT);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,  OP_MULT  = 4'd1,  OP_MULTU = 4'd2,  OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,  OP_MFHI  = 4'd5,  OP_MFLO  = 4'd6,  OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,  OP_MADD  = 4'd9,  OP_MADDU = 4'd10, OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } md_op_e;

  // Ops that occupy the unit for MUL_LAT or DIV_LAT cycles.
  function automatic logic is_multi(input logic [3:0] o);
    logic r;
    case (o)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MD_ACC_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_defined(input logic [3:0] o);
    logic r;
    case (o)
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: r = 1'b1;
      default: r = is_multi(o);
    endcase
    return r;
  endfunction

  // Two's-complement negate at operand width.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, shi_q, shi_d, slo_q, slo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               accept_s, rt_zero_s, a_neg_s, b_neg_s;
  logic [2*WIDTH-1:0] prod_s_s, prod_u_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s, den_u_s, den_s_s;
  logic [WIDTH-1:0]   q_u_s, r_u_s, q_m_s, r_m_s, q_s_s, r_s_s;

  // Datapath: full products and truncating quotients for the presented operands.
  always_comb begin
    prod_s_s  = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
    prod_u_s  = {ZERO_W, rs_data} * {ZERO_W, rt_data};
    rt_zero_s = (rt_data == ZERO_W);
    // A zero divisor is replaced by 1 so the divider never sees 0; the result is overridden anyway.
    den_u_s   = rt_zero_s ? ONE_W : rt_data;
    q_u_s     = rs_data / den_u_s;
    r_u_s     = rs_data % den_u_s;
    a_neg_s   = rs_data[WIDTH-1];
    b_neg_s   = rt_data[WIDTH-1];
    abs_a_s   = a_neg_s ? neg(rs_data) : rs_data;
    abs_b_s   = b_neg_s ? neg(rt_data) : rt_data;
    den_s_s   = rt_zero_s ? ONE_W : abs_b_s;
    q_m_s     = abs_a_s / den_s_s;
    r_m_s     = abs_a_s % den_s_s;
    // MIN / -1 falls out naturally: magnitude 2^(W-1) negates back to MIN, remainder 0.
    q_s_s     = (a_neg_s ^ b_neg_s) ? neg(q_m_s) : q_m_s;
    r_s_s     = a_neg_s ? neg(r_m_s) : r_m_s;
  end

  assign accept_s = valid && !req && !busy_q && is_defined(op);

  // Next state: finish/count down an in-flight op, or start a newly accepted one.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    shi_d  = shi_q;
    slo_d  = slo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      if (cnt_q == CNT_ONE) begin
        hi_d   = shi_q;
        lo_d   = slo_q;
        cnt_d  = CNT_ZERO;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (accept_s) begin
      case (op)
        OP_MULT:  begin {shi_d, slo_d} = prod_s_s; cnt_d = MUL_CNT; busy_d = 1'b1; end
        OP_MULTU: begin {shi_d, slo_d} = prod_u_s; cnt_d = MUL_CNT; busy_d = 1'b1; end
        OP_DIV: begin
          shi_d  = rt_zero_s ? rs_data : r_s_s;
          slo_d  = rt_zero_s ? ONES_W  : q_s_s;
          cnt_d  = DIV_CNT;
          busy_d = 1'b1;
        end
        OP_DIVU: begin
          shi_d  = rt_zero_s ? rs_data : r_u_s;
          slo_d  = rt_zero_s ? ONES_W  : q_u_s;
          cnt_d  = DIV_CNT;
          busy_d = 1'b1;
        end
        OP_MTHI: hi_d = rs_data;
        OP_MTLO: lo_d = rs_data;
`ifdef MD_ACC_EN
        OP_MADD:  begin {shi_d, slo_d} = {hi_q, lo_q} + prod_s_s; cnt_d = MUL_CNT; busy_d = 1'b1; end
        OP_MADDU: begin {shi_d, slo_d} = {hi_q, lo_q} + prod_u_s; cnt_d = MUL_CNT; busy_d = 1'b1; end
        OP_MSUB:  begin {shi_d, slo_d} = {hi_q, lo_q} - prod_s_s; cnt_d = MUL_CNT; busy_d = 1'b1; end
        OP_MSUBU: begin {shi_d, slo_d} = {hi_q, lo_q} - prod_u_s; cnt_d = MUL_CNT; busy_d = 1'b1; end
`endif
        default: begin end
      endcase
    end else begin
      busy_d = 1'b0;
    end
  end

  // State registers with synchronous reset that also discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= ZERO_W;
      lo_q   <= ZERO_W;
      shi_q  <= ZERO_W;
      slo_q  <= ZERO_W;
      cnt_q  <= CNT_ZERO;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      shi_q  <= shi_d;
      slo_q  <= slo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // MFHI/MFLO read port and the precise D-stage stall.
  always_comb begin
    hl_rdata = ZERO_W;
    if (valid && !req && (op == OP_MFHI)) begin
      hl_rdata = hi_q;
    end else if (valid && !req && (op == OP_MFLO)) begin
      hl_rdata = lo_q;
    end else begin
      hl_rdata = ZERO_W;
    end
    stall = d_md_use && (busy_q || (valid && !req && is_multi(op)));
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_md_unit_param.sv
// Self-checking bench for md_unit_param: directed table, hand-written corner
// sequences and randomized traffic against a cycle-level arithmetic model.
module tb_md_unit_param;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;
`ifdef MD_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, req, valid, d_md_use;
  logic [3:0]   op;
  logic [W-1:0] rs_data, rt_data, hl_rdata;
  logic         busy, stall;

  md_unit_param #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .rst(rst), .req(req), .valid(valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .d_md_use(d_md_use),
    .hl_rdata(hl_rdata), .busy(busy), .stall(stall)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural HI/LO, pending result and remaining busy cycles.
  logic [W-1:0] m_hi, m_lo, m_phi, m_plo;
  int           m_cnt;

  function automatic bit m_multi(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd4) || (ACC_EN && o >= 4'd9 && o <= 4'd12);
  endfunction

  function automatic bit m_defined(input logic [3:0] o);
    return m_multi(o) || (o >= 4'd5 && o <= 4'd8);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [63:0] pr, hl;
    longint a, b, q, r;
    if (rst) begin
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (valid && !req && m_defined(op)) begin
      a  = longint'($signed(rs_data));
      b  = longint'($signed(rt_data));
      hl = {m_hi, m_lo};
      if (op == 4'd1 || op == 4'd9 || op == 4'd11) pr = 64'(a * b);
      else pr = {32'd0, rs_data} * {32'd0, rt_data};
      case (op)
        4'd1, 4'd2: begin {m_phi, m_plo} = pr; m_cnt = ML; end
        4'd9, 4'd10: begin {m_phi, m_plo} = hl + pr; m_cnt = ML; end
        4'd11, 4'd12: begin {m_phi, m_plo} = hl - pr; m_cnt = ML; end
        4'd3: begin
          if (b == 0) begin m_plo = '1; m_phi = rs_data; end
          else begin q = a / b; r = a % b; m_plo = q[31:0]; m_phi = r[31:0]; end
          m_cnt = DL;
        end
        4'd4: begin
          if (rt_data == 0) begin m_plo = '1; m_phi = rs_data; end
          else begin m_plo = rs_data / rt_data; m_phi = rs_data % rt_data; end
          m_cnt = DL;
        end
        4'd7: m_hi = rs_data;
        4'd8: m_lo = rs_data;
        default: begin end
      endcase
    end
  endtask

  // Check outputs against the model with current inputs, then clock one edge.
  task automatic cycle();
    logic         eb, es;
    logic [W-1:0] eh;
    #1;
    eb = (m_cnt > 0);
    es = d_md_use && (eb || (valid && !req && m_multi(op)));
    eh = (valid && !req && op == 4'd5) ? m_hi : (valid && !req && op == 4'd6) ? m_lo : '0;
    chk("busy", 64'(busy), 64'(eb));
    chk("stall", 64'(stall), 64'(es));
    chk("hl_rdata", 64'(hl_rdata), 64'(eh));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    valid = 1'b1; req = 1'b0; op = o; rs_data = a; rt_data = b;
    cycle();
    valid = 1'b0; op = 4'd0;
    for (int i = 0; i < 40 && m_cnt > 0; i++) cycle();
    #1 chk("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic read_hl(input string name, input logic [W-1:0] eh, input logic [W-1:0] el);
    valid = 1'b1; req = 1'b0; op = 4'd5;
    #1 chk({name, "_hi"}, 64'(hl_rdata), 64'(eh));
    cycle();
    op = 4'd6;
    #1 chk({name, "_lo"}, 64'(hl_rdata), 64'(el));
    cycle();
    valid = 1'b0; op = 4'd0;
  endtask

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] rs, rt, hi, lo;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{"mult_neg",   4'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{"multu_max",  4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{"mult_ext",   4'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    tbl[3] = '{"divu_zero",  4'd4, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    tbl[4] = '{"div_ovf",    4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5] = '{"div_neg",    4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[6] = '{"divu_basic", 4'd4, 32'd100,      32'd7,        32'd2,        32'd14};
    tbl[7] = '{"div_negdiv", 4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    tbl[8] = '{"div_zero_s", 4'd3, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};

    rst = 1'b1; req = 1'b0; valid = 1'b0; d_md_use = 1'b0; op = 4'd0;
    rs_data = '0; rt_data = '0;
    @(posedge clk); model_edge(); #1;
    @(posedge clk); model_edge(); #1;
    rst = 1'b0;
    d_md_use = 1'b1;
    #1 chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    read_hl("reset", 32'd0, 32'd0);

    // Directed table of arithmetic corner cases.
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].rs, tbl[i].rt);
      read_hl(tbl[i].name, tbl[i].hi, tbl[i].lo);
    end

    // Busy window length for MULT and DIV.
    foreach (tbl[k]) if (k == 0 || k == 4) begin
      valid = 1'b1; op = tbl[k].op; rs_data = tbl[k].rs; rt_data = tbl[k].rt;
      cycle();
      valid = 1'b0; op = 4'd0; n = 0;
      while (busy && n < 30) begin n++; cycle(); end
      chk(k == 0 ? "mult_busy_len" : "div_busy_len", 64'(n), k == 0 ? 64'(ML) : 64'(DL));
      read_hl("busy_len", tbl[k].hi, tbl[k].lo);
    end

    // MTHI under flush is dropped; without flush it is single-cycle.
    rst = 1'b1; cycle(); rst = 1'b0;
    valid = 1'b1; req = 1'b1; op = 4'd7; rs_data = 32'h12345678;
    cycle();
    req = 1'b0; valid = 1'b0;
    read_hl("mthi_flushed", 32'd0, 32'd0);
    valid = 1'b1; op = 4'd7; rs_data = 32'h12345678;
    cycle();
    #1 chk("mthi_busy", 64'(busy), 64'd0);
    read_hl("mthi", 32'h12345678, 32'd0);

    // MADDU accumulate (or NOP when the accumulate ops are not built).
    run_op(4'd7, 32'd0, 32'd0);
    run_op(4'd8, 32'hFFFFFFFF, 32'd0);
    valid = 1'b1; op = 4'd10; rs_data = 32'd1; rt_data = 32'd1; d_md_use = 1'b1;
    #1 chk("maddu_stall", 64'(stall), 64'(ACC_EN));
    run_op(4'd10, 32'd1, 32'd1);
    if (ACC_EN) read_hl("maddu", 32'd1, 32'd0);
    else read_hl("maddu_nop", 32'd0, 32'hFFFFFFFF);

    // Reset during the third busy cycle of a DIV discards everything.
    run_op(4'd1, 32'h00010001, 32'h00030003);
    valid = 1'b1; op = 4'd3; rs_data = 32'd100; rt_data = 32'd7;
    cycle();
    valid = 1'b0; op = 4'd0;
    cycle(); cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    d_md_use = 1'b1;
    #1 chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    read_hl("rst_mid", 32'd0, 32'd0);

    // Randomized traffic, never issuing a new op while the unit is busy.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      req      = ($urandom_range(0, 4) == 0);
      d_md_use = $urandom_range(0, 1);
      valid    = $urandom_range(0, 3) != 0;
      if (m_cnt > 0) begin
        case ($urandom_range(0, 3))
          0: op = 4'd0;
          1: op = 4'd5;
          2: op = 4'd6;
          default: op = 4'd13;
        endcase
      end else begin
        op = 4'($urandom_range(0, 15));
      end
      case ($urandom_range(0, 5))
        0: rt_data = 32'd0;
        1: rt_data = 32'hFFFFFFFF;
        default: rt_data = $urandom;
      endcase
      rs_data = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
